lsu_ctrl: RTL and testbench

Load/store unit sitting between the MEM-stage pipeline logic and the word-organised data memory. Accepts one byte/halfword/word load or store request at a time and generates word-indexed memory read/write strobes. Performs byte-lane extraction with sign/zero extension for loads. Sub-word stores use a registered read-modify-write, because the memory writes whole 32-bit words only. Reports misaligned, out-of-range and illegal requests as an error response without touching memory.

---
 rtl/lsu_ctrl_pkg.sv | 21 ++
 rtl/lsu_ctrl_if.sv | 32 +++
 rtl/lsu_ctrl_lane_align.sv | 59 +++++
 rtl/lsu_ctrl.sv | 126 ++++++++++++
 tb/tb_lsu_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RISC-V
// funct3 width encodings and the default data-memory depth.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SREAD,
        SWRITE,
        RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LSU_MEM_WORDS = 64;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response handshake plus word-memory strobes between the MEM stage,
// the load/store unit and the data memory.
interface lsu_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_ctrl_lane_align.sv
// Combinational byte-lane steering: load extraction with sign/zero extension,
// and the merge of sub-word store data into a previously read memory word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] load_word_i,
    output logic [31:0] load_data_o,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] store_word_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        case (offset_i)
            2'd0:    lane_byte = load_word_i[7:0];
            2'd1:    lane_byte = load_word_i[15:8];
            2'd2:    lane_byte = load_word_i[23:16];
            default: lane_byte = load_word_i[31:24];
        endcase
        lane_half = offset_i[1] ? load_word_i[31:16] : load_word_i[15:0];

        case (funct3_i)
            F3_B:    load_data_o = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_data_o = {24'h0, lane_byte};
            F3_H:    load_data_o = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_data_o = {16'h0, lane_half};
            default: load_data_o = load_word_i;
        endcase
    end

    // Full-word stores pass wdata straight through; the old word is ignored.
    always_comb begin
        store_word_o = old_word_i;
        case (funct3_i)
            F3_B: begin
                case (offset_i)
                    2'd0:    store_word_o[7:0]   = wdata_i[7:0];
                    2'd1:    store_word_o[15:8]  = wdata_i[7:0];
                    2'd2:    store_word_o[23:16] = wdata_i[7:0];
                    default: store_word_o[31:24] = wdata_i[7:0];
                endcase
            end
            F3_H: begin
                if (offset_i[1]) begin
                    store_word_o[31:16] = wdata_i[15:0];
                end else begin
                    store_word_o[15:0] = wdata_i[15:0];
                end
            end
            default: store_word_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit FSM: one request at a time, word-indexed memory strobes,
// read-modify-write for sub-word stores and an error response for bad requests.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = LSU_MEM_WORDS
) (
    input logic       clk,
    input logic       rst,
    lsu_ctrl_if.slave bus
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    lsu_state_e  state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        err_q, err_d;

    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    lsu_lane_align u_align (
        .offset_i     (offset_q),
        .funct3_i     (funct3_q),
        .load_word_i  (bus.mem_rdata),
        .load_data_o  (load_data),
        .old_word_i   (merge_q),
        .wdata_i      (wdata_q),
        .store_word_o (store_word)
    );

    always_comb begin
        req_err = 1'b0;
        if (bus.req_we) begin
            if (!(bus.req_funct3 inside {F3_B, F3_H, F3_W})) req_err = 1'b1;
        end else if (!(bus.req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) begin
            req_err = 1'b1;
        end
        if ((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU) && bus.req_addr[0]) req_err = 1'b1;
        if (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
        if (bus.req_addr >= ADDR_LIMIT) req_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            funct3_q   <= '0;
            offset_q   <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            offset_q   <= offset_d;
            wdata_q    <= wdata_d;
            merge_q    <= merge_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        offset_d   = offset_q;
        wdata_d    = wdata_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    funct3_d   = bus.req_funct3;
                    offset_d   = bus.req_addr[1:0];
                    wdata_d    = bus.req_wdata;
                    mem_addr_d = {2'b00, bus.req_addr[31:2]};
                    err_d      = req_err;
                    rdata_d    = '0;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (!bus.req_we) begin
                        state_d = LOAD;
                    end else if (bus.req_funct3 == F3_W) begin
                        state_d = SWRITE;
                    end else begin
                        state_d = SREAD;
                    end
                end
            end
            LOAD: begin
                rdata_d = load_data;
                state_d = RESP;
            end
            SREAD: begin
                merge_d = bus.mem_rdata;
                state_d = SWRITE;
            end
            SWRITE:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are gated by rst so a write can never commit on a reset edge.
    assign bus.mem_read   = !rst && (state_q == LOAD || state_q == SREAD);
    assign bus.mem_write  = !rst && (state_q == SWRITE);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = (state_q == SWRITE) ? store_word : '0;
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_err   = (state_q == RESP) && err_q;
    assign bus.resp_rdata = (state_q == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a small word memory model, per-cycle capture
// after each accepted request, and hand-computed expectations per scenario.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic preset_en;

    always #5 clk = ~clk;

    lsu_ctrl_if bus ();

    lsu_ctrl #(.MEM_WORDS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:63];

    assign bus.mem_rdata = mem[bus.mem_addr[5:0]];

    always @(posedge clk) begin
        if (preset_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'h8899AABB;
            mem[5]  <= 32'h11223344;
            mem[63] <= 32'hCAFEF00D;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic        c_rv  [8];
    logic        c_err [8];
    logic        c_mr  [8];
    logic        c_mw  [8];
    logic        c_rdy [8];
    logic [31:0] c_rd  [8];
    logic [31:0] c_ma  [8];
    logic [31:0] c_wd  [8];

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
    endtask

    task automatic capture(input int i);
        c_rv[i]  = bus.resp_valid;
        c_err[i] = bus.resp_err;
        c_mr[i]  = bus.mem_read;
        c_mw[i]  = bus.mem_write;
        c_rdy[i] = bus.req_ready;
        c_rd[i]  = bus.resp_rdata;
        c_ma[i]  = bus.mem_addr;
        c_wd[i]  = bus.mem_wdata;
    endtask

    // Present a request in an idle cycle, then capture ncyc cycles after acceptance.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int ncyc);
        @(negedge clk);
        drive_req(we, f3, addr, wd);
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            capture(i);
            if (i == 1) bus.req_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        preset_en = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready got %b exp 1", bus.req_ready); end
        n_checks++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp got %b%b exp 00", bus.resp_valid, bus.resp_err); end
        n_checks++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata got %h exp 0", bus.resp_rdata); end
        n_checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_strobes got %b%b exp 00", bus.mem_read, bus.mem_write); end
        n_checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mem_bus got %h/%h exp 0/0", bus.mem_addr, bus.mem_wdata); end
        rst = 1'b0;
        preset_en = 1'b0;
    endtask

    task automatic test_loads();
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] exp;
        for (int k = 0; k < 6; k++) begin
            case (k)
                0:       begin f3 = F3_B;  addr = 32'h11; exp = 32'hFFFFFFAA; end
                1:       begin f3 = F3_BU; addr = 32'h11; exp = 32'h000000AA; end
                2:       begin f3 = F3_H;  addr = 32'h12; exp = 32'hFFFF8899; end
                3:       begin f3 = F3_HU; addr = 32'h10; exp = 32'h0000AABB; end
                4:       begin f3 = F3_B;  addr = 32'h13; exp = 32'hFFFFFF88; end
                default: begin f3 = F3_W;  addr = 32'hFC; exp = 32'hCAFEF00D; end
            endcase
            run_req(1'b0, f3, addr, 32'h0, 2);
            n_checks++; if ({c_rv[1], c_mr[1], c_mw[1]} !== 3'b010) begin n_fail++; $display("[TB] FAIL load%0d_t1 got rv/rd/wr %b%b%b exp 010", k, c_rv[1], c_mr[1], c_mw[1]); end
            n_checks++; if (c_ma[1] !== (addr >> 2)) begin n_fail++; $display("[TB] FAIL load%0d_addr got %h exp %h", k, c_ma[1], addr >> 2); end
            n_checks++; if ({c_rv[2], c_err[2], c_mr[2]} !== 3'b100) begin n_fail++; $display("[TB] FAIL load%0d_t2 got rv/err/rd %b%b%b exp 100", k, c_rv[2], c_err[2], c_mr[2]); end
            n_checks++; if (c_rd[2] !== exp) begin n_fail++; $display("[TB] FAIL load%0d_rdata got %h exp %h", k, c_rd[2], exp); end
        end
    endtask

    task automatic test_store_word();
        run_req(1'b1, F3_W, 32'h20, 32'hDEADBEEF, 2);
        n_checks++; if ({c_rv[1], c_mr[1], c_mw[1]} !== 3'b001) begin n_fail++; $display("[TB] FAIL sw_t1 got rv/rd/wr %b%b%b exp 001", c_rv[1], c_mr[1], c_mw[1]); end
        n_checks++; if (c_ma[1] !== 32'd8 || c_wd[1] !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL sw_bus got %h/%h exp 8/deadbeef", c_ma[1], c_wd[1]); end
        n_checks++; if ({c_rv[2], c_err[2], c_mw[2]} !== 3'b100 || c_rd[2] !== 32'h0) begin n_fail++; $display("[TB] FAIL sw_resp got %b%b%b rdata %h exp 100 rdata 0", c_rv[2], c_err[2], c_mw[2], c_rd[2]); end
        run_req(1'b0, F3_W, 32'h20, 32'h0, 2);
        n_checks++; if (c_rd[2] !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL sw_readback got %h exp deadbeef", c_rd[2]); end
    endtask

    task automatic test_store_sub();
        run_req(1'b1, F3_B, 32'h12, 32'h12345655, 3);
        n_checks++; if ({c_mr[1], c_mw[1], c_rv[1]} !== 3'b100) begin n_fail++; $display("[TB] FAIL sb_t1 got rd/wr/rv %b%b%b exp 100", c_mr[1], c_mw[1], c_rv[1]); end
        n_checks++; if ({c_mr[2], c_mw[2], c_rv[2]} !== 3'b010) begin n_fail++; $display("[TB] FAIL sb_t2 got rd/wr/rv %b%b%b exp 010", c_mr[2], c_mw[2], c_rv[2]); end
        n_checks++; if (c_ma[2] !== 32'd4 || c_wd[2] !== 32'h8855AABB) begin n_fail++; $display("[TB] FAIL sb_merge got %h/%h exp 4/8855aabb", c_ma[2], c_wd[2]); end
        n_checks++; if ({c_rv[3], c_err[3], c_mw[3]} !== 3'b100 || c_rd[3] !== 32'h0) begin n_fail++; $display("[TB] FAIL sb_resp got %b%b%b rdata %h exp 100 rdata 0", c_rv[3], c_err[3], c_mw[3], c_rd[3]); end
        run_req(1'b0, F3_W, 32'h10, 32'h0, 2);
        n_checks++; if (c_rd[2] !== 32'h8855AABB) begin n_fail++; $display("[TB] FAIL sb_readback got %h exp 8855aabb", c_rd[2]); end
        run_req(1'b1, F3_H, 32'h16, 32'hABCD1234, 3);
        n_checks++; if (c_mw[2] !== 1'b1 || c_ma[2] !== 32'd5 || c_wd[2] !== 32'h12343344) begin n_fail++; $display("[TB] FAIL sh_merge got wr %b %h/%h exp 1 5/12343344", c_mw[2], c_ma[2], c_wd[2]); end
        n_checks++; if (c_rv[3] !== 1'b1 || c_err[3] !== 1'b0) begin n_fail++; $display("[TB] FAIL sh_resp got %b%b exp 10", c_rv[3], c_err[3]); end
    endtask

    task automatic test_errors();
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        for (int k = 0; k < 6; k++) begin
            case (k)
                0:       begin we = 1'b1; f3 = F3_H;   addr = 32'h13;  end
                1:       begin we = 1'b0; f3 = F3_W;   addr = 32'h102; end
                2:       begin we = 1'b0; f3 = 3'b011; addr = 32'h10;  end
                3:       begin we = 1'b1; f3 = F3_BU;  addr = 32'h10;  end
                4:       begin we = 1'b0; f3 = F3_B;   addr = 32'h100; end
                default: begin we = 1'b1; f3 = F3_W;   addr = 32'h22;  end
            endcase
            run_req(we, f3, addr, 32'hFFFFFFFF, 2);
            n_checks++; if ({c_rv[1], c_err[1]} !== 2'b11 || c_rd[1] !== 32'h0) begin n_fail++; $display("[TB] FAIL err%0d_resp got %b%b rdata %h exp 11 rdata 0", k, c_rv[1], c_err[1], c_rd[1]); end
            n_checks++; if ({c_mr[1], c_mw[1], c_mr[2], c_mw[2]} !== 4'b0000) begin n_fail++; $display("[TB] FAIL err%0d_strobes got %b%b%b%b exp 0000", k, c_mr[1], c_mw[1], c_mr[2], c_mw[2]); end
            n_checks++; if (c_rdy[2] !== 1'b1 || c_rv[2] !== 1'b0) begin n_fail++; $display("[TB] FAIL err%0d_idle got rdy %b rv %b exp 1 0", k, c_rdy[2], c_rv[2]); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_req(1'b1, F3_B, 32'h12, 32'h000000EE);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_checks++; if (bus.mem_read !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_sread got %b exp 1", bus.mem_read); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_gate got %b%b exp 00", bus.mem_read, bus.mem_write); end
        @(negedge clk);
        n_checks++; if (bus.mem_write !== 1'b0 || bus.resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_hold got wr %b rv %b exp 0 0", bus.mem_write, bus.resp_valid); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_idle got rdy %b rv %b exp 1 0", bus.req_ready, bus.resp_valid); end
        @(negedge clk);
        n_checks++; if (bus.resp_valid !== 1'b0 || bus.mem_write !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_quiet got rv %b wr %b exp 0 0", bus.resp_valid, bus.mem_write); end
        run_req(1'b0, F3_W, 32'h10, 32'h0, 2);
        n_checks++; if (c_rd[2] !== 32'h8855AABB) begin n_fail++; $display("[TB] FAIL rstmid_word4 got %h exp 8855aabb", c_rd[2]); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_req(1'b0, F3_W, 32'h20, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            capture(i);
            if (i == 1) drive_req(1'b0, F3_BU, 32'h10, 32'h0);
            if (i == 4) bus.req_valid = 1'b0;
        end
        n_checks++; if ({c_rdy[1], c_rdy[2]} !== 2'b00) begin n_fail++; $display("[TB] FAIL b2b_busy1 got %b%b exp 00", c_rdy[1], c_rdy[2]); end
        n_checks++; if (c_rv[2] !== 1'b1 || c_rd[2] !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL b2b_resp1 got rv %b %h exp 1 deadbeef", c_rv[2], c_rd[2]); end
        n_checks++; if (c_rdy[3] !== 1'b1 || c_rv[3] !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_accept got rdy %b rv %b exp 1 0", c_rdy[3], c_rv[3]); end
        n_checks++; if (c_rdy[4] !== 1'b0 || c_mr[4] !== 1'b1 || c_rv[4] !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_load2 got rdy %b rd %b rv %b exp 0 1 0", c_rdy[4], c_mr[4], c_rv[4]); end
        n_checks++; if (c_rv[5] !== 1'b1 || c_rdy[5] !== 1'b0 || c_rd[5] !== 32'h000000BB) begin n_fail++; $display("[TB] FAIL b2b_resp2 got rv %b rdy %b %h exp 1 0 000000bb", c_rv[5], c_rdy[5], c_rd[5]); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store_word();
        test_store_sub();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
